// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl -- decode-stage interlock and forwarding controller for a
// five-stage MIPS pipeline.
//
// A three-entry scoreboard (S1=EX, S2=MEM, S3=WR) records the destination
// register of every instruction in flight. The rs/rt fields being decoded
// are compared against it to produce pipeline holds, bubbles and flushes,
// and to select the EX-stage operand sources.
//
// Build option: define HAZ_FWD_EN to enable operand forwarding. With
// forwarding, only a load-use dependency on S1 stalls. Without it, any
// dependency on S1..S3 stalls, and FwdA/FwdB stay 00.
//
// Ports:
//   Clk, Reset       clock; synchronous active-high reset
//   ID_*             decoded fields/controls of the instruction in ID
//   EX_BranchTaken   branch in EX resolved taken this cycle
//   Stall_PC         hold PC                          (combinational)
//   Stall_IFID       hold IF/ID register              (combinational)
//   Bubble_IDEX      load NOP controls into ID/EX     (combinational)
//   Flush_IFID       clear IF/ID to NOP               (combinational)
//   FwdA, FwdB       EX operand select, registered:
//                    00 regfile, 01 EX/MEM, 10 MEM/WR, 11 WR_RegDin
//   StallCnt         saturating count of stall cycles
module id_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   ID_Valid,
  input  logic [4:0]             ID_Rs,
  input  logic [4:0]             ID_Rt,
  input  logic                   ID_UsesRs,
  input  logic                   ID_UsesRt,
  input  logic                   ID_RegWr,
  input  logic                   ID_MemtoReg,
  input  logic [4:0]             ID_Wdst,
  input  logic                   ID_Jump,
  input  logic                   EX_BranchTaken,
  output logic                   Stall_PC,
  output logic                   Stall_IFID,
  output logic                   Bubble_IDEX,
  output logic                   Flush_IFID,
  output logic [1:0]             FwdA,
  output logic [1:0]             FwdB,
  output logic [STALL_CNT_W-1:0] StallCnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  // Scoreboard: index 0 = S1 (EX), 1 = S2 (MEM), 2 = S3 (WR).
  logic [2:0] sb_v_r;
  logic [4:0] sb_dst_r [3];
  logic [2:0] sb_ld_r;

  logic [2:0] m_rs_s;
  logic [2:0] m_rt_s;
  logic       stall_s;
  logic       issue_v_s;
  logic       cnt_inc_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

`ifdef HAZ_FWD_EN
  // Closest producer wins: S1 -> 01, S2 -> 10, S3 -> 11.
  function automatic logic [1:0] fwd_sel(input logic [2:0] m);
    logic [1:0] sel;
    if (m[0]) begin
      sel = 2'b01;
    end else if (m[1]) begin
      sel = 2'b10;
    end else if (m[2]) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction
`endif

  // Compare each scoreboard entry with the decoded source fields.
  always_comb begin
    m_rs_s = 3'b000;
    m_rt_s = 3'b000;
    for (int k = 0; k < 3; k++) begin
      // $0 is hard-wired: a read of $0 can never depend on anything.
      m_rs_s[k] = sb_v_r[k] & (sb_dst_r[k] == ID_Rs) & ID_UsesRs & (ID_Rs != 5'd0);
      m_rt_s[k] = sb_v_r[k] & (sb_dst_r[k] == ID_Rt) & ID_UsesRt & (ID_Rt != 5'd0);
    end
  end

`ifdef HAZ_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign stall_s = ID_Valid & (m_rs_s[0] | m_rt_s[0]) & sb_ld_r[0];
`else
  // No bypass and no write-through regfile: wait until the producer retires.
  assign stall_s = ID_Valid & ((|m_rs_s) | (|m_rt_s));
  logic unused_ld_s;
  assign unused_ld_s = ^sb_ld_r;
`endif

  // A taken branch kills the ID instruction, so it neither issues nor counts.
  assign issue_v_s = ID_Valid & ID_RegWr & (ID_Wdst != 5'd0) & ~stall_s & ~EX_BranchTaken;
  assign cnt_inc_s = stall_s & ~EX_BranchTaken & ~(&StallCnt);

  // Pipeline control: branch flush overrides a stall, stall overrides jump flush.
  always_comb begin
    Stall_PC    = 1'b0;
    Stall_IFID  = 1'b0;
    Bubble_IDEX = 1'b0;
    Flush_IFID  = 1'b0;
    if (EX_BranchTaken) begin
      Flush_IFID  = 1'b1;
      Bubble_IDEX = 1'b1;
    end else if (stall_s) begin
      Stall_PC    = 1'b1;
      Stall_IFID  = 1'b1;
      Bubble_IDEX = 1'b1;
    end else begin
      Flush_IFID  = ID_Valid & ID_Jump;
    end
  end

  // Forward selects for the instruction about to enter EX.
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
`ifdef HAZ_FWD_EN
    if (ID_Valid & ~Bubble_IDEX & ~Stall_PC & ~Flush_IFID) begin
      fwd_a_s = fwd_sel(m_rs_s);
      fwd_b_s = fwd_sel(m_rt_s);
    end else begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end
`endif
  end

  // Scoreboard shift, registered forward selects and stall counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sb_v_r      <= 3'b000;
      sb_ld_r     <= 3'b000;
      sb_dst_r[0] <= 5'd0;
      sb_dst_r[1] <= 5'd0;
      sb_dst_r[2] <= 5'd0;
      FwdA        <= 2'b00;
      FwdB        <= 2'b00;
      StallCnt    <= '0;
    end else begin
      sb_v_r      <= {sb_v_r[1:0], issue_v_s};
      sb_ld_r     <= {sb_ld_r[1:0], ID_MemtoReg};
      sb_dst_r[2] <= sb_dst_r[1];
      sb_dst_r[1] <= sb_dst_r[0];
      sb_dst_r[0] <= ID_Wdst;
      FwdA        <= fwd_a_s;
      FwdB        <= fwd_b_s;
      if (cnt_inc_s) begin
        StallCnt <= StallCnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  // Expected behaviour for the build under test.
  localparam int         NDEP    = FWD ? 0 : 3;        // ALU->ALU stall cycles
  localparam int         NLU     = FWD ? 1 : 3;        // load-use stall cycles
  localparam logic [1:0] FWD_ALU = FWD ? 2'b01 : 2'b00;
  localparam logic [1:0] FWD_LU  = FWD ? 2'b10 : 2'b00;
  localparam int         PER     = FWD ? 2 : 4;        // self-dependent load repeat period
  localparam int         SMAX    = 7;                  // saturation of the 3-bit counter

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWr, ID_MemtoReg, ID_Jump, EX_BranchTaken;
  logic [4:0]  ID_Rs, ID_Rt, ID_Wdst;
  logic        Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID;
  logic [1:0]  FwdA, FwdB;
  logic [15:0] StallCnt;
  logic        s_pc, s_ifid, s_bub, s_fl;
  logic [1:0]  s_fa, s_fb;
  logic [2:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 Clk = ~Clk;

  id_hazard_ctrl dut (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_RegWr(ID_RegWr),
    .ID_MemtoReg(ID_MemtoReg), .ID_Wdst(ID_Wdst), .ID_Jump(ID_Jump),
    .EX_BranchTaken(EX_BranchTaken), .Stall_PC(Stall_PC), .Stall_IFID(Stall_IFID),
    .Bubble_IDEX(Bubble_IDEX), .Flush_IFID(Flush_IFID), .FwdA(FwdA), .FwdB(FwdB),
    .StallCnt(StallCnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  id_hazard_ctrl #(.STALL_CNT_W(3)) dut_small (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_RegWr(ID_RegWr),
    .ID_MemtoReg(ID_MemtoReg), .ID_Wdst(ID_Wdst), .ID_Jump(ID_Jump),
    .EX_BranchTaken(EX_BranchTaken), .Stall_PC(s_pc), .Stall_IFID(s_ifid),
    .Bubble_IDEX(s_bub), .Flush_IFID(s_fl), .FwdA(s_fa), .FwdB(s_fb),
    .StallCnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Combinational controls {Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID}.
  task automatic ctl(input string tag, input logic [3:0] e);
    @(negedge Clk);
    chk(tag, {12'd0, Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID}, {12'd0, e});
  endtask

  task automatic fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, "_A"}, {14'd0, FwdA}, {14'd0, a});
    chk({tag, "_B"}, {14'd0, FwdB}, {14'd0, b});
  endtask

  task automatic cnt(input string tag);
    int s;
    s = (exp_cnt > SMAX) ? SMAX : exp_cnt;
    chk(tag, StallCnt, 16'(exp_cnt));
    chk({tag, "_sat"}, {13'd0, s_cnt}, 16'(s));
  endtask

  task automatic instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wr, input logic mr,
                       input logic [4:0] wdst, input logic j, input logic br);
    ID_Valid = v; ID_Rs = rs; ID_Rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_RegWr = wr; ID_MemtoReg = mr; ID_Wdst = wdst; ID_Jump = j; EX_BranchTaken = br;
  endtask

  task automatic idle_drain();
    instr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick(); tick(); tick();
  endtask

  initial begin
    // Reset state
    Reset = 1'b1;
    instr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick(); tick();
    Reset = 1'b0;
    fwd("rst_fwd", 2'b00, 2'b00);
    cnt("rst_cnt");
    ctl("rst_ctl", 4'b0000);

    // add $3,$1,$2 ; sub $4,$3,$5
    instr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
    ctl("alu_prod", 4'b0000);
    tick();
    instr(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
    for (int i = 0; i < NDEP; i++) begin
      ctl("alu_stall", 4'b1110);
      tick();
      exp_cnt++;
      fwd("alu_bub", 2'b00, 2'b00);
    end
    ctl("alu_go", 4'b0000);
    tick();
    fwd("alu_fwd", FWD_ALU, 2'b00);
    cnt("alu_cnt");
    idle_drain();

    // lw $3,0($1) ; add $4,$3,$3
    instr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    ctl("lu_load", 4'b0000);
    tick();
    instr(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
    for (int i = 0; i < NLU; i++) begin
      ctl("lu_stall", 4'b1110);
      tick();
      exp_cnt++;
      fwd("lu_bub", 2'b00, 2'b00);
    end
    ctl("lu_go", 4'b0000);
    tick();
    fwd("lu_fwd", FWD_LU, FWD_LU);
    cnt("lu_cnt");
    idle_drain();

    // lw $3 ; dependent add $4,$3,$3 killed by a taken branch in the same cycle
    instr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    ctl("br_load", 4'b0000);
    tick();
    instr(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b1);
    ctl("br_flush", 4'b0011);
    tick();
    fwd("br_fwd", 2'b00, 2'b00);
    cnt("br_cnt");
    // The killed add must not have entered the scoreboard as a $4 producer.
    instr(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
    ctl("br_noissue", 4'b0000);
    tick();
    fwd("br_noissue_fwd", 2'b00, 2'b00);
    idle_drain();

    // j 0x100
    instr(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    ctl("jmp", 4'b0001);
    tick();
    instr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    ctl("jmp_after", 4'b0000);
    cnt("jmp_cnt");

    // Writer of $0 followed by a reader of $0
    instr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    ctl("z_write", 4'b0000);
    tick();
    instr(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0);
    ctl("z_read", 4'b0000);
    tick();
    fwd("z_fwd", 2'b00, 2'b00);
    idle_drain();

    // Reset asserted while a load-use stall is active
    instr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    instr(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
    ctl("rst_mid_stall", 4'b1110);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_cnt = 0;
    fwd("rst_mid_fwd", 2'b00, 2'b00);
    cnt("rst_mid_cnt");
    ctl("rst_mid_after", 4'b0000);
    tick();
    fwd("rst_mid_issue", 2'b00, 2'b00);
    idle_drain();

    // Repeated lw $3,0($3): stalls pile up and saturate the 3-bit counter
    instr(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      logic e;
      e = ((i % PER) != 0);
      ctl("sat_ctl", {e, e, e, 1'b0});
      tick();
      if (e) exp_cnt++;
      cnt("sat_cnt");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline interlock and forwarding controller for the decode stage of the five-stage MIPS pipeline. It tracks destination registers of instructions in flight in EX, MEM and WR with a three-entry scoreboard shift register. It compares them with the rs/rt fields being decoded, and drives PC/IF-ID hold, ID/EX bubble insertion, IF/ID flush and registered operand-forwarding selects for the EX stage. It sits beside the decode stage and consumes its decoded control outputs.

## Interface
- STALL_CNT_W, 16, width of the saturating stall-cycle counter
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- ID_Valid  in  1  decode stage holds a real instruction
- ID_Rs, ID_Rt  in  5 each  source register fields of the decoding instruction
- ID_UsesRs, ID_UsesRt  in  1 each  instruction actually reads rs / rt
- ID_RegWr  in  1  decoding instruction writes the register file
- ID_MemtoReg  in  1  decoding instruction is a load
- ID_Wdst  in  5  resolved destination (RegDst ? rd : rt)
- ID_Jump  in  1  decoding instruction is j
- EX_BranchTaken  in  1  branch in EX resolved taken this cycle
- Stall_PC  out  1  hold PC
- Stall_IFID  out  1  hold IF/ID register
- Bubble_IDEX  out  1  load NOP controls into ID/EX
- Flush_IFID  out  1  clear IF/ID to NOP
- FwdA, FwdB  out  2 each  EX operand source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WR result, 11 WR_RegDin
- StallCnt  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- Scoreboard entries S1 (EX), S2 (MEM), S3 (WR), each {v, dst[4:0], ld}. The shift occurs every cycle: S3<=S2, S2<=S1, S1<=issue.
- The issue entry is v=ID_Valid & ID_RegWr & (ID_Wdst!=0) & !stall & !EX_BranchTaken, with dst=ID_Wdst and ld=ID_MemtoReg. Otherwise S1 gets v=0.
- Match rule: Mk_s = Sk.v & (Sk.dst==ID_s) & ID_Uses_s, for s∈{Rs,Rt}. Register $0 never matches.
- Hazard stall (with forwarding): stall = ID_Valid & (M1_Rs | M1_Rt) & S1.ld. This is load-use only.
- stall drives Stall_PC=Stall_IFID=Bubble_IDEX=1.
- Flush on EX_BranchTaken:
  - Flush_IFID=1 and Bubble_IDEX=1.
  - Stall_PC=Stall_IFID=0, because the flush overrides the stall for the wrong-path instruction in ID.
- Flush on jump: ID_Valid & ID_Jump & !stall & !EX_BranchTaken gives Flush_IFID=1 for one cycle. The jump itself issues normally.
- Forward selects are computed in ID and registered into FwdA/FwdB on the edge where the instruction enters EX.
  - Priority is S1 (01), then S2 (10), then S3 (11), else 00.
  - On a cycle with a bubble, stall or flush, FwdA/FwdB register 00.
- StallCnt increments by 1 on each cycle with stall=1 and holds at all-ones.

## Timing
- Stall_PC, Stall_IFID, Bubble_IDEX and Flush_IFID are combinational, valid in the same cycle as the ID inputs.
- FwdA/FwdB are registered with 1-cycle latency and aligned with the instruction in EX.
- Load-use produces exactly 1 stall cycle. On the next cycle the load is in S2, and the dependent instruction gets Fwd=10.
- Simultaneous stall and EX_BranchTaken: the flush wins, with no stall count and no issue.
- Reset:
  - All S*.v=0, FwdA=FwdB=00, StallCnt=0.
  - The combinational outputs read 0 while ID_Valid=0 and EX_BranchTaken=0.
  - Reset mid-stall discards the scoreboard. The first post-reset instruction sees no hazards.

## Configuration
- HAZ_FWD_EN defined: forwarding as above.
- HAZ_FWD_EN undefined:
  - FwdA=FwdB held at 00.
  - stall = ID_Valid & (any Mk_s for k∈{1,2,3}), with S3 included since the register file is not write-through.
  - A back-to-back ALU dependency stalls 3 cycles while S1→S3 drain.
  - Flush and jump behaviour is unchanged.

## Test plan
- add $3,$1,$2 followed by sub $4,$3,$5 (FWD_EN): 0 stalls. FwdA=01 in the sub's EX cycle. StallCnt stays 0.
- lw $3,0($1) followed by add $4,$3,$3: exactly 1 cycle with Stall_PC=Bubble_IDEX=1. Then FwdA=FwdB=10. StallCnt=1.
- Without HAZ_FWD_EN, add $3,... followed by add $4,$3,$0: 3 stall cycles. FwdA stays 00. StallCnt=3.
- lw $3 followed by a dependent instruction, with EX_BranchTaken=1 in the same cycle: Flush_IFID=1, Bubble_IDEX=1, Stall_PC=0. StallCnt unchanged.
- j 0x100 in ID: Flush_IFID=1 for exactly one cycle, with no stall.
- Writes to $0, Reset asserted mid-stall, and StallCnt saturation:
  - An instruction writing $0 never triggers a hazard.
  - Reset asserted mid-stall clears outputs next cycle.
  - StallCnt preloaded to 0xFFFF stays at 0xFFFF on a further stall.
